preproc_flag_packer: RTL and testbench
======================================

PREPROC_FLAG_PACKER -- requirements
Module: preproc_flag_packer

Interface
REQ-001 SHALL have parameter FRAME_W, default 1280, pixels per line; multiple of 4.
REQ-002 SHALL have parameter FRAME_H, default 720, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, output FIFO depth in 32-bit words; power of 2, at least 4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port i_valid  input  1  pixel flag set valid this cycle.
REQ-007 SHALL have port i_sof  input  1  first pixel of a frame; qualified by i_valid.
REQ-008 SHALL have ports i_edge, i_thresh, i_motion  input  1 each  per-pixel feature flags.
REQ-009 SHALL have port i_color  input  2  per-pixel colour class.
REQ-010 SHALL have port m_data  output  32  packed word to downstream consumer.
REQ-011 SHALL have port m_valid  output  1  m_data/m_last valid.
REQ-012 SHALL have port m_last  output  1  final word of a frame.
REQ-013 SHALL have port m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.
REQ-014 SHALL have port o_frame_cnt  output  16  frames started since reset.
REQ-015 SHALL have port o_overflow  output  1  sticky: a word was dropped on a full FIFO.
REQ-016 SHALL have port o_short  output  1  sticky: a frame was cut short by an early i_sof.

Function
REQ-017 SHALL encode each pixel as a byte: bit0 edge, bit1 thresh, bit2 motion, bits4:3 color, bits7:5 zero.
REQ-018 SHALL pack 4 consecutive pixels per word; the first of the four goes in bits 7:0, the last in bits 31:24.
REQ-019 SHALL use state machine IDLE/PACK. IDLE ignores i_valid pixels without i_sof. i_valid&i_sof in any state moves to PACK and counts as pixel 0.
REQ-020 SHALL, on each accepted i_sof, write a header word {16'hF5A0, o_frame_cnt} into the FIFO in that cycle's write slot and then increment o_frame_cnt (wraps 0xFFFF->0x0000).
REQ-021 SHALL write a data word into the FIFO in the cycle after the 4th pixel of a group; m_last=1 only on the word holding pixel FRAME_W*FRAME_H-1; header words carry m_last=0.
REQ-022 SHALL, after writing the m_last word, return to IDLE; further pixels without i_sof are discarded.
REQ-023 SHALL, on i_sof while in PACK with pixel count not 0 mod 4 or below FRAME_W*FRAME_H, discard the incomplete group, set o_short, and start the new frame (header plus pixel 0); no m_last is emitted for the cut frame.
REQ-024 SHALL, when i_sof lands on a 4-pixel boundary, write the completed prior data word before the new header.
REQ-025 SHALL, to meet REQ-024, hold a one-word staging register so both writes occur on consecutive cycles with no pixel loss.
REQ-026 SHALL, when the FIFO is full at a write slot, drop that word (header or data) and set o_overflow; the pixel counter still advances.
REQ-027 SHALL present a registered FIFO output; m_valid stays high until the handshake; m_data and m_last stay stable while m_valid&!m_ready.
REQ-028 SHALL give a latency, with FIFO empty and m_ready high, of exactly 2 cycles from the 4th pixel's i_valid cycle to m_valid.
REQ-029 SHALL treat simultaneous FIFO write and read when full as a read first, then a write accepted with no overflow.
REQ-030 SHALL sustain full throughput with i_valid high every cycle and m_ready high: 1 word per 4 cycles plus 1 per frame.

Reset
REQ-031 SHALL, with rst high at a clock edge, clear state to IDLE, pixel counter, staging register, FIFO (empty), o_frame_cnt=0, o_overflow=0, o_short=0, m_valid=0, m_last=0, m_data=0.
REQ-032 SHALL, for rst mid-frame, drop partial words and all FIFO content; the first word output after reset is a header with count 0.

Verification (FRAME_W=8, FRAME_H=2, FIFO_DEPTH=4 unless noted)
REQ-033 SHALL verify the nominal frame: i_sof + 16 pixels with i_color=2'b01, all flags 1, m_ready=1 -> header 0xF5A00000, then 4 words 0x0F0F0F0F, m_last only on the 4th, o_frame_cnt=1.
REQ-034 SHALL verify lane order: pixels with edge only, thresh only, motion only, color=3 -> word 0x18040201.
REQ-035 SHALL verify backpressure: m_ready=0 for a full frame -> FIFO holds 4 words, 5th write dropped, o_overflow=1, held m_data stable; release -> 4 words drain in order.
REQ-036 SHALL verify early sof: i_sof after 6 pixels -> 1 data word, no m_last, o_short=1, new header 0xF5A00001.
REQ-037 SHALL verify wrap and reset: preload o_frame_cnt via 65536 headers (FRAME_W=4, FRAME_H=1) -> header 0xF5A0FFFF then 0xF5A00000; rst mid-frame -> m_valid=0 next cycle, first output after reset 0xF5A00000.

Source files
------------

// File: rtl/preproc_flag_packer.sv
// preproc_flag_packer: packs per-pixel feature flags four to a 32-bit word, with frame headers, into an output FIFO
module preproc_flag_packer #(
  parameter int FRAME_W    = 1280,
  parameter int FRAME_H    = 720,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic        i_edge,
  input  logic        i_thresh,
  input  logic        i_motion,
  input  logic [1:0]  i_color,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] o_frame_cnt,
  output logic        o_overflow,
  output logic        o_short
);
  localparam int NPIX = FRAME_W * FRAME_H;
  localparam int CW = $clog2(NPIX) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HDR = 16'hF5A0;
  typedef enum logic {IDLE, PACK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] pix_q, pix_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] stg_q, stg_d;
  logic stg_v_q, stg_v_d, stg_last_q, stg_last_d;
  logic [15:0] pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic [15:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, short_q, short_d;
  logic [32:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] mcnt_q, mcnt_d;
  logic [31:0] dout_q, dout_d;
  logic last_q, last_d, val_q, val_d;
  logic [7:0] px;
  logic sof, pix, pop, full, wr_req, wr_en, ld;
  logic [32:0] wr_word;
  always_comb begin
    px = {3'b000, i_color, i_motion, i_thresh, i_edge};
    sof = i_valid && i_sof;
    pix = i_valid && !i_sof && state_q == PACK;
    state_d = state_q;
    pix_d = pix_q;
    acc_d = acc_q;
    stg_d = stg_q;
    stg_v_d = 1'b0;
    stg_last_d = stg_last_q;
    cnt_d = cnt_q;
    short_d = short_q;
    if (sof) begin
      state_d = PACK;
      pix_d = CW'(1);
      acc_d[7:0] = px;
      cnt_d = cnt_q + 16'd1;
      short_d = short_q || state_q == PACK;
    end else if (pix) begin
      pix_d = pix_q + CW'(1);
      if (pix_q[1:0] == 2'd3) begin
        stg_v_d = 1'b1;
        stg_d = {px, acc_q};
        stg_last_d = pix_q == CW'(NPIX - 1);
        state_d = stg_last_d ? IDLE : PACK;
      end else begin
        acc_d[{pix_q[1:0], 3'b000} +: 8] = px;
      end
    end
    // a header colliding with a staged data word waits one cycle behind it
    pend_v_d = sof ? (stg_v_q || pend_v_q) : (pend_v_q && stg_v_q);
    pend_d = (sof && (stg_v_q || pend_v_q)) ? cnt_q : pend_q;
    wr_req = stg_v_q || pend_v_q || sof;
    wr_word = stg_v_q ? {stg_last_q, stg_q} : pend_v_q ? {1'b0, HDR, pend_q} : {1'b0, HDR, cnt_q};
    pop = val_q && m_ready;
    full = (mcnt_q + (AW+1)'(val_q)) == (AW+1)'(FIFO_DEPTH) && !pop;
    wr_en = wr_req && !full;
    ovf_d = ovf_q || (wr_req && full);
    ld = (!val_q || m_ready) && mcnt_q != '0;
    mcnt_d = mcnt_q + (AW+1)'(wr_en) - (AW+1)'(ld);
    wp_d = wp_q + AW'(wr_en);
    rp_d = rp_q + AW'(ld);
    val_d = ld || (val_q && !m_ready);
    dout_d = ld ? mem_q[rp_q][31:0] : dout_q;
    last_d = ld ? mem_q[rp_q][32] : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q <= '0;
      acc_q <= '0;
      stg_q <= '0;
      stg_v_q <= 1'b0;
      stg_last_q <= 1'b0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      short_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      mcnt_q <= '0;
      dout_q <= '0;
      last_q <= 1'b0;
      val_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      acc_q <= acc_d;
      stg_q <= stg_d;
      stg_v_q <= stg_v_d;
      stg_last_q <= stg_last_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      short_q <= short_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mcnt_q <= mcnt_d;
      dout_q <= dout_d;
      last_q <= last_d;
      val_q <= val_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= wr_word;
  end
  assign m_data = dout_q;
  assign m_last = last_q;
  assign m_valid = val_q;
  assign o_frame_cnt = cnt_q;
  assign o_overflow = ovf_q;
  assign o_short = short_q;
endmodule

// File: tb/tb_preproc_flag_packer.sv
// tb_preproc_flag_packer: directed and random frames checked against a pixel-list reference model
module tb_preproc_flag_packer;
  localparam int W = 8, H = 2, D = 4, NPIX = W * H;
  logic clk = 0, rst = 1;
  logic i_valid = 0, i_sof = 0, i_edge = 0, i_thresh = 0, i_motion = 0;
  logic [1:0] i_color = 0;
  logic [31:0] m_data;
  logic m_valid, m_last, m_ready = 1;
  logic [15:0] o_frame_cnt;
  logic o_overflow, o_short;
  logic i_valid2 = 0, i_sof2 = 0, m_ready2 = 1;
  logic [31:0] m_data2;
  logic m_valid2, m_last2;
  logic [15:0] o_frame_cnt2;
  logic o_overflow2, o_short2;
  preproc_flag_packer #(.FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_edge(i_edge),
    .i_thresh(i_thresh), .i_motion(i_motion), .i_color(i_color), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .o_frame_cnt(o_frame_cnt),
    .o_overflow(o_overflow), .o_short(o_short));
  preproc_flag_packer #(.FRAME_W(4), .FRAME_H(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid2), .i_sof(i_sof2), .i_edge(1'b0),
    .i_thresh(1'b0), .i_motion(1'b0), .i_color(2'b00), .m_data(m_data2),
    .m_valid(m_valid2), .m_last(m_last2), .m_ready(m_ready2), .o_frame_cnt(o_frame_cnt2),
    .o_overflow(o_overflow2), .o_short(o_short2));
  always #5 clk = ~clk;
  int n_asrt = 0, n_fail = 0;
  logic [32:0] expq[$];
  logic [7:0] m_buf[$];
  logic [15:0] m_fc = 0, exp2 = 0;
  logic [31:0] last2 = 0, prev2 = 0;
  bit m_in = 0, mon_en = 1, mon2_en = 0;
  int m_pix = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // reference: frame = header then groups of four pixel bytes; partial groups vanish on a new sof
  task automatic model_px(bit sof, logic [7:0] b);
    if (sof) begin
      expq.push_back({1'b0, 16'hF5A0, m_fc});
      m_fc++;
      m_in = 1;
      m_buf = {b};
      m_pix = 1;
    end else if (m_in) begin
      m_buf.push_back(b);
      m_pix++;
      if (m_buf.size() == 4) begin
        expq.push_back({m_pix == NPIX, m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
        m_buf.delete();
        if (m_pix == NPIX) m_in = 0;
      end
    end
  endtask
  task automatic px(bit sof, logic [7:0] b);
    i_valid = 1;
    i_sof = sof;
    {i_color, i_motion, i_thresh, i_edge} = b[4:0];
    model_px(sof, b);
    @(posedge clk); #1;
    i_valid = 0;
    i_sof = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] rb();
    return 8'($urandom_range(0, 31));
  endfunction
  task automatic drain(string tag);
    idle(6);
    for (int i = 0; i < 200 && expq.size() != 0; i++) idle(1);
    chk(tag, expq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (mon_en && !rst && m_valid && m_ready) begin
      logic [32:0] e;
      e = (expq.size() != 0) ? expq.pop_front() : {33{1'bx}};
      n_asrt++;
      assert ({m_last, m_data} === e) else begin
        n_fail++;
        $error("FAIL out_word observed=%h expected=%h", {m_last, m_data}, e);
      end
    end
  end
  always @(negedge clk) begin
    if (mon2_en && !rst && m_valid2 && m_ready2) begin
      n_asrt++;
      assert ({m_last2, m_data2} === {1'b0, 16'hF5A0, exp2}) else begin
        n_fail++;
        $error("FAIL wrap_hdr observed=%h expected=%h", {m_last2, m_data2}, {1'b0, 16'hF5A0, exp2});
      end
      prev2 = last2;
      last2 = m_data2;
      exp2++;
    end
  end
  initial begin
    logic [15:0] fc;
    logic [32:0] bp_exp[4];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_short", o_short, 0);
    rst = 0;
    idle(1);
    px(0, 8'h1F);
    px(1, 8'h0F);
    repeat (15) px(0, 8'h0F);
    px(0, 8'h0F);
    drain("nominal_drain");
    chk("nominal_fcnt", o_frame_cnt, 1);
    chk("nominal_short", o_short, 0);
    chk("nominal_ovf", o_overflow, 0);
    idle(2);
    px(1, 8'h01);
    px(0, 8'h02);
    px(0, 8'h04);
    px(0, 8'h18);
    idle(1);
    chk("lat_early", m_valid, 0);
    idle(1);
    chk("lat_valid", m_valid, 1);
    chk("lane_word", m_data, 32'h18040201);
    chk("lane_last", m_last, 0);
    repeat (12) px(0, rb());
    drain("lane_drain");
    fc = m_fc;
    px(1, rb());
    repeat (5) px(0, rb());
    px(1, rb());
    repeat (15) px(0, rb());
    drain("early_drain");
    chk("early_short", o_short, 1);
    chk("early_fcnt", o_frame_cnt, fc + 16'd2);
    px(1, rb());
    repeat (7) px(0, rb());
    px(1, rb());
    repeat (3) px(0, rb());
    px(1, rb());
    repeat (15) px(0, rb());
    px(1, rb());
    repeat (15) px(0, rb());
    drain("boundary_drain");
    for (int f = 0; f < 10; f++) begin
      int k;
      repeat ($urandom_range(0, 3)) px(0, rb());
      px(1, rb());
      k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : 15;
      for (int p = 0; p < k; p++) begin
        px(0, rb());
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
    end
    drain("random_drain");
    mon_en = 0;
    m_ready = 0;
    fc = m_fc;
    px(1, 8'h0F);
    repeat (15) px(0, 8'h0F);
    expq.delete();
    idle(3);
    chk("bp_ovf", o_overflow, 1);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, {16'hF5A0, fc});
    idle(3);
    chk("bp_hold", {m_last, m_data}, {1'b0, 16'hF5A0, fc});
    bp_exp[0] = {1'b0, 16'hF5A0, fc};
    for (int i = 1; i < 4; i++) bp_exp[i] = {1'b0, 32'h0F0F0F0F};
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", m_valid, 1);
      chk("bp_drain_word", {m_last, m_data}, bp_exp[i]);
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_empty", m_valid, 0);
    #1;
    mon_en = 1;
    @(posedge clk); #1;
    mon2_en = 1;
    i_valid2 = 1;
    i_sof2 = 1;
    repeat (65537) @(posedge clk);
    #1;
    i_valid2 = 0;
    i_sof2 = 0;
    idle(5);
    chk("wrap_count", exp2, 1);
    chk("wrap_ffff", prev2, 32'hF5A0FFFF);
    chk("wrap_zero", last2, 32'hF5A00000);
    chk("wrap_fcnt", o_frame_cnt2, 1);
    chk("wrap_ovf", o_overflow2, 0);
    mon2_en = 0;
    m_ready2 = 0;
    i_valid2 = 1;
    i_sof2 = 1;
    @(posedge clk); #1;
    i_sof2 = 0;
    repeat (2) @(posedge clk);
    #1;
    i_valid2 = 0;
    chk("mid_pre_valid", m_valid2, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_valid", m_valid2, 0);
    chk("mid_rst_data", m_data2, 0);
    chk("mid_rst_fcnt", o_frame_cnt2, 0);
    chk("mid_rst_short", o_short2, 0);
    rst = 0;
    m_ready2 = 1;
    i_valid2 = 1;
    i_sof2 = 1;
    @(posedge clk); #1;
    i_valid2 = 0;
    i_sof2 = 0;
    for (int i = 0; i < 10 && !m_valid2; i++) begin
      @(posedge clk); #1;
    end
    chk("post_rst_valid", m_valid2, 1);
    chk("post_rst_head", m_data2, 32'hF5A00000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
